// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - shared-bus arbiter/router: round-robin or fixed priority, one packet per grant
// Define BUS_ARB_BCAST_LOOPBACK_EN to include the source in the broadcast mask.
module bus_rr_arbiter #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mode,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              D_push,
    output logic                            err_addr,
    output logic                            busy
);

    localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t               state_q, state_d;
    logic [pckg_sz-1:0]   data_q, data_d, d_push_d;
    logic [IW-1:0]        src_q, src_d, last_q, last_d, win;
    logic [drvrs-1:0]     pop_d, push_d, mask;
    logic                 err_d, busy_d, found, is_bcast, legal;
    logic [7:0]           dest;
    int                   rr_idx;

    // Winner selection; round-robin starts one past the previous winner and wraps.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        rr_idx = 0;
        if (mode) begin
            for (int i = drvrs - 1; i >= 0; i--) begin
                if (pndng[i]) win = IW'(i);
            end
        end else begin
            for (int k = 1; k <= drvrs; k++) begin
                rr_idx = int'(last_q) + k;
                if (rr_idx >= drvrs) rr_idx = rr_idx - drvrs;
                if (!found && pndng[IW'(rr_idx)]) begin
                    win   = IW'(rr_idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Destination decode of the captured packet; illegal codes leave the mask empty.
    always_comb begin
        dest     = data_q[pckg_sz-1 -: 8];
        is_bcast = (dest == broadcast);
        legal    = is_bcast || (int'(dest) < drvrs);
        mask     = '0;
        if (is_bcast) begin
            mask = '1;
`ifndef BUS_ARB_BCAST_LOOPBACK_EN
            mask[src_q] = 1'b0;
`endif
        end else begin
            for (int i = 0; i < drvrs; i++) begin
                if (int'(dest) == i) mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pop_d    = '0;
        push_d   = '0;
        err_d    = 1'b0;
        d_push_d = D_push;
        data_d   = data_q;
        src_d    = src_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (|pndng) begin
                    pop_d[win] = 1'b1;
                    data_d     = D_pop[win];
                    src_d      = win;
                    last_d     = win;
                    state_d    = POP;
                end
            end
            POP: begin
                d_push_d = data_q;
                push_d   = mask;
                err_d    = !legal;
                state_d  = PUSH;
            end
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pop      <= '0;
            push     <= '0;
            D_push   <= '0;
            err_addr <= 1'b0;
            busy     <= 1'b0;
            data_q   <= '0;
            src_q    <= '0;
            last_q   <= IW'(drvrs - 1);
        end else begin
            state_q  <= state_d;
            pop      <= pop_d;
            push     <= push_d;
            D_push   <= d_push_d;
            err_addr <= err_d;
            busy     <= busy_d;
            data_q   <= data_d;
            src_q    <= src_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                mode = 1'b0;
    logic [N-1:0]        pndng = '0;
    logic [N-1:0][W-1:0] d_pop = '0;
    logic [N-1:0]        pop, push;
    logic [W-1:0]        D_push;
    logic                err_addr, busy;

    int tests_run = 0;
    int fails = 0;
    int m_last = N - 1;
    logic [W-1:0] fifo [N][$];

    bus_rr_arbiter #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .mode(mode), .pndng(pndng), .D_pop(d_pop),
        .pop(pop), .push(push), .D_push(D_push), .err_addr(err_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_winner(logic [N-1:0] pend, logic m, int last);
        if (m) begin
            for (int i = 0; i < N; i++) if (pend[i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] ref_mask(logic [W-1:0] data, int src);
        int dest;
        logic [N-1:0] m;
        dest = int'(data[W-1 -: 8]);
        m = '0;
        if (dest == 255) begin
            m = '1;
`ifndef BUS_ARB_BCAST_LOOPBACK_EN
            m[src] = 1'b0;
`endif
        end else if (dest < N) begin
            m[dest] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic ref_err(logic [W-1:0] data);
        int dest;
        dest = int'(data[W-1 -: 8]);
        return (dest != 255) && (dest >= N);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pndng = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_last = N - 1;
    endtask

    // Waits (bounded) for a grant; p stays 0 on timeout so the caller's compare fails.
    task automatic wait_grant(output logic [N-1:0] p, output int n);
        p = '0;
        n = 0;
        while (n < 20 && p == '0) begin
            @(negedge clk);
            n++;
            if (pop !== '0) p = pop;
        end
    endtask

    task automatic apply_fifos();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (fifo[i].size() != 0);
            d_pop[i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if ({pop, push, err_addr, busy} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: pop=%b push=%b err=%b busy=%b, want all 0", pop, push, err_addr, busy);
        end
        tests_run++;
        if (D_push !== '0) begin
            fails++;
            $display("FAIL reset_dpush: got %h want 0000", D_push);
        end
        @(negedge clk);
        reset = 1'b0;
        m_last = N - 1;
    endtask

    task automatic test_unicast();
        logic [N-1:0] p;
        int n;
        do_reset();
        mode = 1'b0;
        d_pop[0] = 16'h02AB;
        pndng = 4'b0001;
        wait_grant(p, n);
        pndng = '0;
        tests_run++;
        if (p !== 4'b0001 || busy !== 1'b1) begin
            fails++;
            $display("FAIL uni_pop: pop=%b busy=%b want 0001/1", p, busy);
        end
        @(negedge clk);
        tests_run++;
        if (pop !== '0 || push !== 4'b0100 || D_push !== 16'h02AB || busy !== 1'b1 || err_addr !== 1'b0) begin
            fails++;
            $display("FAIL uni_push: pop=%b push=%b D_push=%h busy=%b err=%b want 0000/0100/02ab/1/0",
                     pop, push, D_push, busy, err_addr);
        end
        @(negedge clk);
        tests_run++;
        if (push !== '0 || busy !== 1'b0 || D_push !== 16'h02AB) begin
            fails++;
            $display("FAIL uni_idle: push=%b busy=%b D_push=%h want 0000/0/02ab", push, busy, D_push);
        end
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] p;
        int n;
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < N; i++) d_pop[i] = {8'h01, 8'(i)};
        pndng = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(p, n);
            tests_run++;
            if (p !== (4'(1) << (g % N))) begin
                fails++;
                $display("FAIL rr_grant%0d: pop=%b want %b", g, p, 4'(1) << (g % N));
            end
            if (g > 0) begin
                tests_run++;
                if (n != 2) begin
                    fails++;
                    $display("FAIL rr_spacing%0d: gap %0d cycles want 3", g, n + 1);
                end
            end
            @(negedge clk);
            tests_run++;
            if (push !== 4'b0010 || D_push !== {8'h01, 8'(g % N)}) begin
                fails++;
                $display("FAIL rr_push%0d: push=%b D_push=%h want 0010/%h", g, push, D_push, {8'h01, 8'(g % N)});
            end
        end
        pndng = '0;
    endtask

    task automatic test_fixed_priority();
        logic [N-1:0] p;
        int n;
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < N; i++) d_pop[i] = {8'h00, 8'(i)};
        pndng = 4'b1010;
        for (int g = 0; g < 3; g++) begin
            wait_grant(p, n);
            tests_run++;
            if (p !== 4'b0010) begin
                fails++;
                $display("FAIL fp_grant%0d: pop=%b want 0010", g, p);
            end
            @(negedge clk);
        end
        mode = 1'b0;
        wait_grant(p, n);
        tests_run++;
        if (p !== 4'b1000) begin
            fails++;
            $display("FAIL fp_to_rr: pop=%b want 1000", p);
        end
        pndng = '0;
        @(negedge clk);
    endtask

    task automatic test_broadcast();
        logic [N-1:0] p;
        logic [N-1:0] want;
        int n;
`ifdef BUS_ARB_BCAST_LOOPBACK_EN
        want = 4'b1111;
`else
        want = 4'b1011;
`endif
        do_reset();
        d_pop[2] = 16'hFF55;
        pndng = 4'b0100;
        wait_grant(p, n);
        pndng = '0;
        @(negedge clk);
        tests_run++;
        if (p !== 4'b0100 || push !== want || D_push !== 16'hFF55 || err_addr !== 1'b0) begin
            fails++;
            $display("FAIL bcast: pop=%b push=%b D_push=%h err=%b want 0100/%b/ff55/0", p, push, D_push, err_addr, want);
        end
    endtask

    task automatic test_illegal();
        logic [N-1:0] p;
        int n;
        do_reset();
        d_pop[1] = 16'h0711;
        pndng = 4'b0010;
        wait_grant(p, n);
        pndng = '0;
        tests_run++;
        if (p !== 4'b0010) begin
            fails++;
            $display("FAIL ill_pop: pop=%b want 0010", p);
        end
        @(negedge clk);
        tests_run++;
        if (push !== '0 || err_addr !== 1'b1) begin
            fails++;
            $display("FAIL ill_err: push=%b err=%b want 0000/1", push, err_addr);
        end
        @(negedge clk);
        tests_run++;
        if (push !== '0 || err_addr !== 1'b0) begin
            fails++;
            $display("FAIL ill_pulse: push=%b err=%b want 0000/0", push, err_addr);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] p;
        logic [W-1:0] pkt;
        logic [7:0]   dst;
        int n, ew, total, guard;
        do_reset();
        total = 0;
        for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = $urandom_range(1, 6);
            for (int j = 0; j < cnt; j++) begin
                case ($urandom_range(0, 5))
                    4:       dst = 8'hFF;
                    5:       dst = 8'($urandom_range(N, 254));
                    default: dst = 8'($urandom_range(0, N - 1));
                endcase
                fifo[i].push_back({dst, 8'($urandom)});
                total++;
            end
        end
        guard = 0;
        while (total > 0 && guard < 100) begin
            guard++;
            mode = 1'($urandom);
            apply_fifos();
            ew = ref_winner(pndng, mode, m_last);
            wait_grant(p, n);
            tests_run++;
            if (ew < 0 || p !== (4'(1) << ew)) begin
                fails++;
                $display("FAIL rnd_grant: pop=%b want winner %0d (mode %0d)", p, ew, mode);
            end
            if (ew < 0) break;
            m_last = ew;
            pkt = fifo[ew].pop_front();
            total--;
            apply_fifos();
            @(negedge clk);
            tests_run++;
            if (push !== ref_mask(pkt, ew) || D_push !== pkt || err_addr !== ref_err(pkt)) begin
                fails++;
                $display("FAIL rnd_push: src %0d pkt %h push=%b D_push=%h err=%b want %b/%h/%b",
                         ew, pkt, push, D_push, err_addr, ref_mask(pkt, ew), pkt, ref_err(pkt));
            end
        end
        pndng = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] p;
        int n;
        do_reset();
        mode = 1'b0;
        d_pop[0] = 16'h02CD;
        pndng = 4'b0001;
        wait_grant(p, n);
        pndng = '0;
        @(negedge clk);
        tests_run++;
        if (push !== 4'b0100) begin
            fails++;
            $display("FAIL rmid_pre: push=%b want 0100", push);
        end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (push !== '0 || D_push !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rmid_async: push=%b D_push=%h busy=%b want 0000/0000/0", push, D_push, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) d_pop[i] = {8'h00, 8'(i)};
        pndng = 4'b1111;
        wait_grant(p, n);
        pndng = '0;
        tests_run++;
        if (p !== 4'b0001) begin
            fails++;
            $display("FAIL rmid_first: pop=%b want 0001", p);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_rr_fairness();
        test_fixed_priority();
        test_broadcast();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
